exe_mem_skid: RTL

Parametrised EXE→MEM pipeline register with valid/ready handshaking, a two-entry skid buffer, synchronous flush and a saturating stall counter. It sits between the execute and memory stages and replaces the free-running stage latch. Downstream back-pressure now stalls the pipe without losing or duplicating instructions. Branch/exception flushes now squash in-flight entries. Every payload field (IR, PC, Z, Addr) is forwarded intact.

---
 rtl/exe_mem_skid_pkg.sv | 15 +
 rtl/exe_mem_skid_buf.sv | 78 +++++++
 rtl/exe_mem_skid.sv | 65 ++++++
 3 files changed

// File: rtl/exe_mem_skid_pkg.sv
// Shared defaults and types for the EXE/MEM pipeline register and the
// reusable skid buffer.
package exe_mem_skid_pkg;

    localparam int unsigned EXE_WIDTH = 32;
    localparam int unsigned EXE_CNT_W = 16;
    localparam logic [EXE_WIDTH-1:0] EXE_NOP = '0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/exe_mem_skid_buf.sv
// Generic two-entry skid buffer with valid/ready handshake and synchronous
// flush. in_ready and out_valid are registered decodes of the state.
module pipe_skid_buf
    import exe_mem_skid_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_t   state;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic          xfer_in;
    logic          xfer_out;

    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;
    assign out_data = main_q;

    // State machine, storage and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        main_q    <= in_data;
                        state     <= ST_ONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_q <= in_data;
                    end else if (xfer_in) begin
                        skid_q   <= in_data;
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (xfer_out) begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (xfer_out) begin
                        main_q   <= skid_q;
                        state    <= ST_ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_mem_skid.sv
// EXE->MEM pipeline register: packs the payload into the skid buffer,
// substitutes NOP on IR when idle and counts back-pressure cycles.
module exe_mem_skid
    import exe_mem_skid_pkg::*;
#(
    parameter int unsigned          WIDTH = EXE_WIDTH,
    parameter logic [WIDTH-1:0]     NOP   = WIDTH'(EXE_NOP),
    parameter int unsigned          CNT_W = EXE_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   IR_in,
    input  logic [WIDTH-3:0]   PC_in,
    input  logic [WIDTH-1:0]   Z_in,
    input  logic [WIDTH-1:0]   Addr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   IR_out,
    output logic [WIDTH-3:0]   PC_out,
    output logic [WIDTH-1:0]   Z_out,
    output logic [WIDTH-1:0]   Addr_out,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int unsigned DW = 4 * WIDTH - 2;

    logic [DW-1:0]    in_data;
    logic [DW-1:0]    out_data;
    logic [WIDTH-1:0] ir_q;

    assign in_data = {IR_in, PC_in, Z_in, Addr_in};
    assign {ir_q, PC_out, Z_out, Addr_out} = out_data;

    pipe_skid_buf #(
        .DW (DW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Idle slots present the NOP encoding to MEM
    always_comb begin
        IR_out = out_valid ? ir_q : NOP;
    end

    // Saturating count of cycles where MEM holds off a valid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
